ibex_shared_sram_arb: RTL and testbench

// - N-port ibex-style (req/gnt/rvalid) front-end onto one internal single-port SRAM; replaces the
//   two separate always-granting memories of the tiny SoC.
// - Adds arbitration, real backpressure, configurable read latency, base relocation and
//   out-of-range error responses. Sits between the cellift core's instr/data ports and memory.

---
 rtl/ibex_shared_sram_arb_pkg.sv | 18 +
 rtl/ibex_shared_sram_arb_rr_arbiter.sv | 52 +++++
 rtl/ibex_shared_sram_arb.sv | 122 ++++++++++++
 tb/tb_ibex_shared_sram_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_shared_sram_arb_pkg.sv
// Shared types and helpers for the arbitrated single-port SRAM front-end.
package ibex_shared_sram_arb_pkg;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte address is backed by storage iff its word offset from base is below depth.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/ibex_shared_sram_arb_rr_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module ibex_rr_arbiter
  import ibex_shared_sram_arb_pkg::*;
#(
  parameter int unsigned  N          = 2,
  parameter bit           RoundRobin = 1'b1,
  localparam int unsigned IdxW       = idx_width(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW:0]   cand;
  logic            found;

  // With RoundRobin=0 the pointer stays at 0, so the same search is fixed priority.
  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(N)) cand = cand - (IdxW+1)'(N);
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      gnt_o[i] = found && !rst_i && (gnt_idx_o == IdxW'(i));
    end
  end

  assign ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (RoundRobin && (|gnt_o)) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ibex_shared_sram_arb.sv
// N-port req/gnt/rvalid front-end onto one single-port SRAM with fixed-latency,
// in-order responses, base relocation and out-of-range error responses.
module ibex_shared_sram_arb
  import ibex_shared_sram_arb_pkg::*;
#(
  parameter int unsigned NumPorts    = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned Depth       = 1 << 20,
  parameter int unsigned ReadLatency = 1,
  parameter logic [31:0] BaseAddr    = 32'h8000_0000,
  parameter bit          RoundRobin  = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumPorts-1:0]       req_i,
  output logic [NumPorts-1:0]       gnt_o,
  input  logic [NumPorts-1:0]       we_i,
  input  logic [NumPorts*32-1:0]    addr_i,
  input  logic [NumPorts*Width-1:0] wdata_i,
  input  logic [NumPorts*Width-1:0] strb_i,
  output logic [NumPorts-1:0]       rvalid_o,
  output logic [NumPorts*Width-1:0] rdata_o,
  output logic [NumPorts-1:0]       err_o
);

  localparam int unsigned IdxW  = idx_width(NumPorts);
  localparam int unsigned WordW = idx_width(Depth);

  if (NumPorts < 1) begin : g_chk_ports
    $error("ibex_shared_sram_arb: NumPorts must be >= 1");
  end
  if (ReadLatency < 1) begin : g_chk_latency
    $error("ibex_shared_sram_arb: ReadLatency must be >= 1");
  end
  if (Depth > (32'd1 << 30)) begin : g_chk_depth
    $error("ibex_shared_sram_arb: Depth must be <= 2^30");
  end
  if (BaseAddr[1:0] != 2'b00) begin : g_chk_base
    $error("ibex_shared_sram_arb: BaseAddr must be word aligned");
  end

  typedef struct packed {
    logic             valid;
    logic [IdxW-1:0]  idx;
    logic             err;
    logic [Width-1:0] data;
  } resp_stage_t;

  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_any;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [Width-1:0] sel_wdata;
  logic [Width-1:0] sel_strb;
  logic             hit;
  logic [WordW-1:0] word;

  logic [Width-1:0] mem_q [Depth];

  resp_stage_t stage_d;
  resp_stage_t stage_q [ReadLatency];
  resp_stage_t last;

  ibex_rr_arbiter #(
    .N          (NumPorts),
    .RoundRobin (RoundRobin)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx)
  );

  assign gnt_any   = |gnt_o;
  assign sel_we    = we_i[gnt_idx];
  assign sel_addr  = addr_i[gnt_idx*32 +: 32];
  assign sel_wdata = wdata_i[gnt_idx*Width +: Width];
  assign sel_strb  = strb_i[gnt_idx*Width +: Width];
  assign hit       = in_range(sel_addr, BaseAddr, Depth);
  assign word      = WordW'((sel_addr - BaseAddr) >> 2);

  // Storage is deliberately not reset; only in-range granted writes touch it.
  always_ff @(posedge clk_i) begin
    if (gnt_any && sel_we && hit) begin
      mem_q[word] <= (mem_q[word] & ~sel_strb) | (sel_wdata & sel_strb);
    end
  end

  always_comb begin
    stage_d       = '0;
    stage_d.valid = gnt_any;
    stage_d.idx   = gnt_idx;
    stage_d.err   = gnt_any && !hit;
    stage_d.data  = (gnt_any && !sel_we && hit) ? mem_q[word] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= stage_d;
      for (int i = 1; i < ReadLatency; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign last = stage_q[ReadLatency-1];

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (last.valid && (last.idx == IdxW'(p))) begin
        rvalid_o[p]                = 1'b1;
        err_o[p]                   = last.err;
        rdata_o[p*Width +: Width]  = last.data;
      end
    end
  end

endmodule

// File: tb/tb_ibex_shared_sram_arb.sv
// Directed and scoreboarded bench for ibex_shared_sram_arb across three configurations.
`timescale 1ns/1ps
module tb_ibex_shared_sram_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A: 2 ports, latency 3, round-robin
  logic        rst_a;
  logic [1:0]  req_a, gnt_a, we_a, rvalid_a, err_a;
  logic [63:0] addr_a, wdata_a, strb_a, rdata_a;
  // B: 2 ports, latency 2, fixed priority
  logic        rst_b;
  logic [1:0]  req_b, gnt_b, we_b, rvalid_b, err_b;
  logic [63:0] addr_b, wdata_b, strb_b, rdata_b;
  // C: 3 ports, latency 2, round-robin
  logic        rst_c;
  logic [2:0]  req_c, gnt_c, we_c, rvalid_c, err_c;
  logic [95:0] addr_c, wdata_c, strb_c, rdata_c;

  ibex_shared_sram_arb #(.NumPorts(2), .Width(32), .Depth(64), .ReadLatency(3),
                         .BaseAddr(32'h8000_0000), .RoundRobin(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .gnt_o(gnt_a), .we_i(we_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .strb_i(strb_a),
    .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a));

  ibex_shared_sram_arb #(.NumPorts(2), .Width(32), .Depth(64), .ReadLatency(2),
                         .BaseAddr(32'h8000_0000), .RoundRobin(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .strb_i(strb_b),
    .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b));

  ibex_shared_sram_arb #(.NumPorts(3), .Width(32), .Depth(64), .ReadLatency(2),
                         .BaseAddr(32'h8000_0000), .RoundRobin(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst_c), .req_i(req_c), .gnt_o(gnt_c), .we_i(we_c),
    .addr_i(addr_c), .wdata_i(wdata_c), .strb_i(strb_c),
    .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c));

  // One transfer on A, checking grant, exact latency (3) and response contents.
  task automatic a_xfer(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] strb,
                        input logic [31:0] exp_data, input logic exp_err);
    logic [1:0] oh;
    oh = 2'b01 << p;
    @(negedge clk);
    req_a = '0;
    req_a[p] = 1'b1;
    we_a[p] = we;
    addr_a[p*32 +: 32]  = addr;
    wdata_a[p*32 +: 32] = wdata;
    strb_a[p*32 +: 32]  = strb;
    #1 chk("a_gnt", gnt_a, oh);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_a = '0;
      chk("a_rvalid", rvalid_a, (k == 3) ? oh : 2'b00);
      if (k == 3) begin
        chk("a_rdata", rdata_a[p*32 +: 32], exp_data);
        chk("a_err", err_a[p], exp_err);
        chk("a_rdata_other", rdata_a[(1-p)*32 +: 32], 0);
      end
    end
  endtask

  // Scoreboard state for C
  typedef struct packed {
    logic [1:0]  port;
    logic        err;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mdl_mem [64];
  logic        op_v    [3];
  logic        op_we   [3];
  logic [31:0] op_addr [3];
  logic [31:0] op_wd   [3];
  logic [31:0] op_st   [3];
  int          cyc      = 0;
  int          c_ptr    = 0;
  int          ops_left = 0;
  int          pre_w    = 0;
  int          n_xfer   = 0;

  // One cycle on C, entered and left at a falling edge.
  task automatic c_cycle(input bit preload);
    exp_t        e;
    logic [2:0]  rq, oh;
    logic [31:0] off;
    int          g, idx, r;
    if (expq.size() > 0 && expq[0].due == 32'(cyc)) begin
      e  = expq.pop_front();
      oh = 3'b001 << e.port;
      chk("c_rvalid", rvalid_c, oh);
      chk("c_rdata", rdata_c[e.port*32 +: 32], e.data);
      chk("c_err", err_c[e.port], e.err);
    end else begin
      chk("c_rvalid_idle", rvalid_c, 0);
    end
    for (int p = 0; p < 3; p++) begin
      if (!op_v[p] && ops_left > 0 && (!preload || p == 0)) begin
        op_v[p] = 1'b1;
        ops_left--;
        if (preload) begin
          op_we[p]   = 1'b1;
          op_addr[p] = 32'h8000_0000 + 32'(4 * pre_w);
          op_wd[p]   = $urandom;
          op_st[p]   = 32'hFFFF_FFFF;
          pre_w++;
        end else begin
          op_we[p] = 1'($urandom_range(0, 1));
          r = $urandom_range(0, 7);
          if (r == 0)      op_addr[p] = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15));
          else if (r == 1) op_addr[p] = 32'h7FFF_FFF0;
          else             op_addr[p] = 32'h8000_0000 + 32'(4 * $urandom_range(0, 63));
          op_wd[p] = $urandom;
          op_st[p] = $urandom;
        end
      end
    end
    rq = {op_v[2], op_v[1], op_v[0]};
    req_c = rq;
    for (int p = 0; p < 3; p++) begin
      we_c[p] = op_we[p];
      addr_c[p*32 +: 32]  = op_addr[p];
      wdata_c[p*32 +: 32] = op_wd[p];
      strb_c[p*32 +: 32]  = op_st[p];
    end
    #1;
    if (rq != 3'b000) begin
      g = -1;
      for (int i = 0; i < 3; i++) begin
        idx = (c_ptr + i) % 3;
        if (g < 0 && rq[idx]) g = idx;
      end
      oh = 3'b001 << g;
      chk("c_gnt", gnt_c, oh);
      e.port = 2'(g);
      e.due  = 32'(cyc + 2);
      off    = op_addr[g] - 32'h8000_0000;
      if ((off >> 2) < 32'd64) begin
        e.err = 1'b0;
        if (op_we[g]) begin
          mdl_mem[off[7:2]] = (mdl_mem[off[7:2]] & ~op_st[g]) | (op_wd[g] & op_st[g]);
          e.data = 32'h0;
        end else begin
          e.data = mdl_mem[off[7:2]];
        end
      end else begin
        e.err  = 1'b1;
        e.data = 32'h0;
      end
      expq.push_back(e);
      op_v[g] = 1'b0;
      c_ptr   = (g + 1) % 3;
      n_xfer++;
    end else begin
      chk("c_gnt_idle", gnt_c, 0);
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int iters;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = 2'b11; we_a = '0; addr_a = '0; wdata_a = '0; strb_a = '0;
    req_b = '0;    we_b = '0; addr_b = '0; wdata_b = '0; strb_b = '0;
    req_c = '0;    we_c = '0; addr_c = '0; wdata_c = '0; strb_c = '0;
    for (int p = 0; p < 3; p++) begin
      op_v[p] = 1'b0; op_we[p] = 1'b0; op_addr[p] = '0; op_wd[p] = '0; op_st[p] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt_forced", gnt_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_c_rvalid", rvalid_c, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = '0;

    // A: preload, latency-3 read, strobed write, out-of-range handling
    a_xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    a_xfer(1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    a_xfer(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 1'b0);
    a_xfer(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_FF00, 32'h0, 1'b0);
    a_xfer(1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h1234_FF78, 1'b0);
    a_xfer(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b1);
    a_xfer(0, 1'b0, 32'h8000_0100, 32'h0, 32'h0, 32'h0, 1'b1);
    a_xfer(0, 1'b1, 32'h8000_0100, 32'hBAD0_BAD0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    a_xfer(1, 1'b1, 32'h7FFF_FFFC, 32'hBAD0_BAD0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    a_xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h1234_FF78, 1'b0);
    a_xfer(1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // A: continuous contention alternates, pointer is at port 0 here
    @(negedge clk);
    req_a = 2'b11; we_a = 2'b00;
    addr_a = {32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      #1 chk("a_rr", gnt_a, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    req_a = '0;

    // B: fixed priority starves port 1; writes respond with zero data after 2 cycles
    @(negedge clk);
    req_b = 2'b11; we_b = 2'b11;
    addr_b  = {32'h8000_0004, 32'h8000_0000};
    wdata_b = {32'h1111_1111, 32'h2222_2222};
    strb_b  = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      #1 chk("b_fixed_gnt", gnt_b, 2'b01);
      chk("b_rvalid", rvalid_b, (i >= 2) ? 2'b01 : 2'b00);
      chk("b_rdata", rdata_b, 0);
      chk("b_err", err_b, 0);
      @(negedge clk);
    end
    req_b[0] = 1'b0;
    #1 chk("b_port1_gnt", gnt_b, 2'b10);
    @(negedge clk);
    req_b = '0;

    // C: reset one cycle after a grant drops the response but keeps the write
    req_c = 3'b010; we_c = 3'b010;
    addr_c[32 +: 32]  = 32'h8000_0014;
    wdata_c[32 +: 32] = 32'hA5A5_0001;
    strb_c[32 +: 32]  = 32'hFFFF_FFFF;
    #1 chk("c_gnt_pre", gnt_c, 3'b010);
    @(negedge clk);
    rst_c = 1'b1; req_c = 3'b111;
    #1 chk("c_rst_gnt", gnt_c, 0);
    chk("c_rst_rvalid", rvalid_c, 0);
    chk("c_rst_rdata", rdata_c, 0);
    chk("c_rst_err", err_c, 0);
    @(negedge clk);
    rst_c = 1'b0; req_c = '0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("c_dropped", rvalid_c, 0);
      @(negedge clk);
    end
    we_c = 3'b000;
    addr_c = {32'h8000_0014, 32'h8000_0014, 32'h8000_0014};
    req_c = 3'b111;
    #1 chk("c_post_rst_gnt", gnt_c, 3'b001);
    @(negedge clk);
    req_c = '0;
    #1 chk("c_post_rst_rv1", rvalid_c, 0);
    @(negedge clk);
    #1 chk("c_post_rst_rv2", rvalid_c, 3'b001);
    chk("c_post_rst_data", rdata_c[31:0], 32'hA5A5_0001);
    chk("c_post_rst_err", err_c, 0);
    @(negedge clk);
    c_ptr = 1;

    // C: preload every word through port 0, then 100 random back-to-back transfers
    ops_left = 64;
    iters = 0;
    while ((ops_left > 0 || op_v[0]) && iters < 200) begin
      c_cycle(1'b1);
      iters++;
    end
    chk("c_preload_cycles", iters, 64);
    ops_left = 100;
    n_xfer = 0;
    iters = 0;
    while ((ops_left > 0 || op_v[0] || op_v[1] || op_v[2]) && iters < 300) begin
      c_cycle(1'b0);
      iters++;
    end
    chk("c_throughput", iters, 100);
    chk("c_xfers", n_xfer, 100);
    for (int k = 0; k < 4; k++) c_cycle(1'b0);
    chk("c_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
